gate_chip_checker: RTL and testbench
====================================

# gate_chip_checker

Parametrised tester for 74xx-series single-function gate chips (inverters, NAND, NOR, AND, OR, XOR, XNOR, buffers). It drives every input combination onto all gates of the device under test and waits a settle time after each drive. It then compares the synchronised gate outputs against the selected logic function and reports pass/fail with a per-gate failure mask. It sits between the board-level pin mux and the result display/controller in the chip-checker design.

## Interface
Parameters:
- N_GATES, 4, number of gates on the chip (1..8)
- N_IN, 2, inputs per gate (1..4)
- SETTLE, 4, cycles each vector is held before compare (must be ≥3)

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset; clock Clk
- Run  in  1  start request, sampled only in HALTED
- Func  in  3  gate function: 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 BUF, 7 NOT (BUF/NOT use input bit 0 only)
- DISP_RSLT  in  1  result acknowledged; releases DONE
- Drive  out  N_GATES*N_IN  chip input pins; gate g uses bits [g*N_IN +: N_IN]
- Sense  in  N_GATES  chip output pins, asynchronous to Clk
- Done  out  1  high while in DONE
- RSLT  out  1  1 = all gates passed
- FailMask  out  N_GATES  bit g set = gate g mismatched at least once

## Operation
- Sense passes through a 2-flop synchroniser before any use.
- States: HALTED, SET, DRIVE, CHECK, DONE.
- HALTED: Drive = 0. If Run = 1, go to SET; otherwise stay.
- SET (1 cycle): latch Func into FuncReg, set vec = 0, FailMask = 0, RSLT = 0, settle counter = 0. Go to DRIVE.
- DRIVE: even gates get vec; odd gates get ~vec, so shorts between adjacent gates are detected. The counter increments each cycle. When counter = SETTLE-1, go to CHECK.
- CHECK (1 cycle): Drive is unchanged. For each gate, expected = FuncReg applied to that gate's driven bits. Each mismatch ORs its bit into FailMask.
  - If vec = 2^N_IN-1: go to DONE. RSLT is computed from the updated FailMask: RSLT = (FailMask == 0).
  - Else: vec increments, counter = 0, go back to DRIVE.
- DONE: Done = 1, Drive = 0. Run is ignored. When DISP_RSLT = 1, go to HALTED; otherwise stay.
- Func changes after SET have no effect until the next SET.
- RSLT and FailMask hold their values through DONE and HALTED until the next SET or Reset.

## Timing
- Reset values: state HALTED, Drive 0, Done 0, RSLT 0, FailMask 0, vec 0, synchroniser flops 0.
- Reset mid-test takes effect on the next edge and aborts the test; no partial result is reported.
- Run sampled high at edge k → SET at k+1 → DRIVE at k+2. Done rises 2 + 2^N_IN·(SETTLE+1) cycles after edge k.
- Each vector takes SETTLE+1 cycles. With the 2-flop synchroniser, this gives SETTLE-2 cycles of true settle margin.
- DISP_RSLT sampled high in DONE → HALTED and Done = 0 on the next edge. A new Run is accepted one cycle later.
- DISP_RSLT and Run asserted in the same cycle while in DONE → HALTED. Run is not retained.

## Configuration
- CHIP_CHECK_CAPTURE_EN defined:
  - Adds outputs FirstFailVec [N_IN-1:0] and FirstFailValid [1]. Both are cleared at SET and on Reset.
  - At the first CHECK with any mismatch, FirstFailVec ← vec and FirstFailValid ← 1. Later mismatches do not overwrite them.
- Not defined: these ports and their registers are absent; all other behaviour is identical.

## Test plan
All scenarios use N_GATES=4, N_IN=2, SETTLE=4, a behavioural chip model, and CHIP_CHECK_CAPTURE_EN defined unless noted.
- Good NAND model, Func=1, Run pulse → Done 22 cycles after Run edge, RSLT=1, FailMask=4'b0000, FirstFailValid=0.
- NAND model with gate 2 stuck-at-1 → RSLT=0, FailMask=4'b0100, FirstFailVec=2'b11.
- NOR model tested with Func=1 → RSLT=0, FailMask=4'b1111, FirstFailVec=2'b01.
- Reset asserted 10 cycles into a test → next edge: Done=0, Drive=0, FailMask=0. A fresh Run completes normally in 22 cycles.
- In DONE with DISP_RSLT=0, Run pulsed 3 times → Done stays 1 and results are unchanged. DISP_RSLT=1 → Done=0 and state HALTED next edge.
- Build without CHIP_CHECK_CAPTURE_EN, N_GATES=6, N_IN=1, good NOT model, Func=7 → Done 12 cycles after Run, RSLT=1, FailMask=6'b0.

Source files
------------

// File: rtl/gate_chip_checker_if.sv
// gate_chip_checker_if: controller handshake, chip pins and results of the gate tester.
// CHIP_CHECK_CAPTURE_EN adds the first-failing-vector capture signals.
interface gate_chip_checker_if #(
  parameter int N_GATES = 4,
  parameter int N_IN = 2
);
  logic Run;
  logic [2:0] Func;
  logic DISP_RSLT;
  logic [N_GATES*N_IN-1:0] Drive;
  logic [N_GATES-1:0] Sense;
  logic Done;
  logic RSLT;
  logic [N_GATES-1:0] FailMask;
`ifdef CHIP_CHECK_CAPTURE_EN
  logic [N_IN-1:0] FirstFailVec;
  logic FirstFailValid;
  modport master (output Run, Func, DISP_RSLT, Sense, input Drive, Done, RSLT, FailMask, FirstFailVec, FirstFailValid);
  modport slave (input Run, Func, DISP_RSLT, Sense, output Drive, Done, RSLT, FailMask, FirstFailVec, FirstFailValid);
`else
  modport master (output Run, Func, DISP_RSLT, Sense, input Drive, Done, RSLT, FailMask);
  modport slave (input Run, Func, DISP_RSLT, Sense, output Drive, Done, RSLT, FailMask);
`endif
endinterface

// File: rtl/gate_chip_checker.sv
// gate_chip_checker: exhaustive vector tester for 74xx single-function gate chips.
// CHIP_CHECK_CAPTURE_EN adds FirstFailVec/FirstFailValid capture of the first failing vector.
module gate_chip_checker #(
  parameter int N_GATES = 4,
  parameter int N_IN = 2,
  parameter int SETTLE = 4
) (
  input logic Clk,
  input logic Reset,
  gate_chip_checker_if.slave bus
);
  localparam int CW = $clog2(SETTLE);
  typedef enum logic [2:0] {HALTED, SET, DRIVE, CHECK, DONE} state_t;
  state_t state, state_nx;
  logic run_q;
  logic [2:0] func_reg;
  logic [N_IN-1:0] vec;
  logic [CW-1:0] cnt;
  logic [N_GATES-1:0] sense_s1, sense_s2, expect_v, mism, mask_nx, fail_mask;
  logic [N_GATES*N_IN-1:0] pattern;
  logic rslt, settled, last_vec;
  // odd gates see the complement so a short to a neighbour always disagrees somewhere
  for (genvar g = 0; g < N_GATES; g++) begin : gen_gate
    logic [N_IN-1:0] b;
    assign b = (g % 2) == 1 ? ~vec : vec;
    assign pattern[g*N_IN +: N_IN] = b;
    assign expect_v[g] = func_reg[2:1] == 2'd0 ? &b ^ func_reg[0] :
                         func_reg[2:1] == 2'd1 ? |b ^ func_reg[0] :
                         func_reg[2:1] == 2'd2 ? ^b ^ func_reg[0] : b[0] ^ func_reg[0];
  end
  assign settled = cnt == CW'(SETTLE - 1);
  assign last_vec = &vec;
  assign mism = expect_v ^ sense_s2;
  assign mask_nx = fail_mask | mism;
  always_comb begin
    state_nx = state == HALTED ? (run_q ? SET : HALTED) :
               state == SET    ? DRIVE :
               state == DRIVE  ? (settled ? CHECK : DRIVE) :
               state == CHECK  ? (last_vec ? DONE : DRIVE) :
               state == DONE   ? (bus.DISP_RSLT ? HALTED : DONE) : HALTED;
    bus.Drive = state == DRIVE || state == CHECK ? pattern : '0;
    bus.Done = state == DONE;
  end
  // Run is captured only while HALTED, so a Run seen in DONE is never carried over
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= HALTED;
      run_q <= 1'b0;
      sense_s1 <= '0;
      sense_s2 <= '0;
      func_reg <= '0;
      vec <= '0;
      cnt <= '0;
      fail_mask <= '0;
      rslt <= 1'b0;
    end else begin
      state <= state_nx;
      run_q <= state == HALTED && bus.Run;
      sense_s1 <= bus.Sense;
      sense_s2 <= sense_s1;
      if (state == SET) begin
        func_reg <= bus.Func;
        vec <= '0;
        cnt <= '0;
        fail_mask <= '0;
        rslt <= 1'b0;
      end
      if (state == DRIVE) cnt <= settled ? '0 : cnt + 1'b1;
      if (state == CHECK) begin
        fail_mask <= mask_nx;
        if (last_vec) rslt <= mask_nx == '0;
        else vec <= vec + 1'b1;
      end
    end
  end
  assign bus.FailMask = fail_mask;
  assign bus.RSLT = rslt;
`ifdef CHIP_CHECK_CAPTURE_EN
  logic [N_IN-1:0] ff_vec;
  logic ff_valid;
  always_ff @(posedge Clk) begin
    if (Reset || state == SET) begin
      ff_vec <= '0;
      ff_valid <= 1'b0;
    end else if (state == CHECK && mism != '0 && !ff_valid) begin
      ff_vec <= vec;
      ff_valid <= 1'b1;
    end
  end
  assign bus.FirstFailVec = ff_vec;
  assign bus.FirstFailValid = ff_valid;
`endif
endmodule

// File: tb/tb_gate_chip_checker.sv
// tb_gate_chip_checker: time-indexed model of a 4x2-input tester run against behavioural chips,
// plus literal checks and a 6-gate inverter build.
module tb_gate_chip_checker;
  localparam int P = 5;
  localparam int TDONE = 2 + 4 * P;
  typedef struct packed {logic [3:0] mask; logic valid; logic [1:0] vec; logic rslt;} res_t;
  logic Clk = 0;
  logic Reset = 1;
  always #5 Clk = ~Clk;
  gate_chip_checker_if #(.N_GATES(4), .N_IN(2)) a_if ();
  gate_chip_checker_if #(.N_GATES(6), .N_IN(1)) b_if ();
  gate_chip_checker #(.N_GATES(4), .N_IN(2), .SETTLE(4)) dut_a (.Clk(Clk), .Reset(Reset), .bus(a_if.slave));
  gate_chip_checker #(.N_GATES(6), .N_IN(1), .SETTLE(4)) dut_b (.Clk(Clk), .Reset(Reset), .bus(b_if.slave));
  int vecs = 0;
  int errs = 0;
  int chip_mode = 0;
  bit chk_en = 0;
  // chip modes: 0 good NAND, 1 NAND with gate 2 stuck high, 2 NOR
  function automatic logic [3:0] chip(input int mode, input logic [7:0] d);
    logic [3:0] r;
    for (int g = 0; g < 4; g++) r[g] = mode == 2 ? ~(d[2*g] | d[2*g+1]) : ~(d[2*g] & d[2*g+1]);
    if (mode == 1) r[2] = 1'b1;
    return r;
  endfunction
  function automatic logic fexp(input logic [2:0] f, input logic [1:0] bits);
    int ones;
    ones = $countones(bits);
    case (f)
      3'd0: return ones == 2;
      3'd1: return ones != 2;
      3'd2: return ones > 0;
      3'd3: return ones == 0;
      3'd4: return ones % 2 == 1;
      3'd5: return ones % 2 == 0;
      3'd6: return bits[0];
      default: return !bits[0];
    endcase
  endfunction
  function automatic logic [7:0] pat(input int v);
    logic [1:0] x;
    x = 2'(v);
    return {~x, x, ~x, x};
  endfunction
  function automatic logic [3:0] mism(input logic [2:0] f, input int mode, input int v);
    logic [7:0] p;
    logic [3:0] got, m;
    p = pat(v);
    got = chip(mode, p);
    for (int g = 0; g < 4; g++) m[g] = got[g] ^ fexp(f, p[2*g +: 2]);
    return m;
  endfunction
  function automatic res_t results(input bit hv, input logic [2:0] f, input int mode, input int k);
    res_t r;
    logic [3:0] m;
    r = '0;
    if (!hv) return r;
    for (int v = 0; v < k; v++) begin
      m = mism(f, mode, v);
      if (m != 0 && !r.valid) begin
        r.valid = 1'b1;
        r.vec = 2'(v);
      end
      r.mask = r.mask | m;
    end
    r.rslt = k == 4 && r.mask == 0;
    return r;
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always_comb a_if.Sense = chip(chip_mode, a_if.Drive);
  assign b_if.Sense = ~b_if.Drive;
  // model: ph 0 idle, 1 testing (t = edges since Run was sampled), 2 done
  int ph = 0;
  int t = 0;
  int mm = 0;
  int kdone;
  bit have = 0;
  logic [2:0] mf = 0;
  res_t er;
  always @(posedge Clk) begin
    if (Reset) begin
      ph <= 0;
      have <= 0;
    end else if (ph == 0) begin
      if (a_if.Run) begin
        ph <= 1;
        t <= 0;
      end
    end else if (ph == 2) begin
      if (a_if.DISP_RSLT) ph <= 0;
    end else begin
      t <= t + 1;
      if (t + 1 == 2) begin
        mf <= a_if.Func;
        mm <= chip_mode;
        have <= 1;
      end
      if (t + 1 == TDONE) ph <= 2;
    end
  end
  always_comb kdone = ph == 1 && t >= 2 ? (t - 2) / P : 4;
  always_comb er = results(have, mf, mm, kdone);
  always @(negedge Clk) begin
    if (chk_en) begin
      check("Done", 32'(a_if.Done), 32'(ph == 2));
      check("Drive", 32'(a_if.Drive), 32'(ph == 1 && t >= 2 ? pat((t - 2) / P) : 8'd0));
      check("FailMask", 32'(a_if.FailMask), 32'(er.mask));
      check("RSLT", 32'(a_if.RSLT), 32'(er.rslt));
`ifdef CHIP_CHECK_CAPTURE_EN
      check("FirstFailValid", 32'(a_if.FirstFailValid), 32'(er.valid));
      check("FirstFailVec", 32'(a_if.FirstFailVec), 32'(er.valid ? er.vec : 2'd0));
`endif
    end
  end
  task automatic run_a(input logic [2:0] late_func, output int lat, output logic [7:0] d2);
    a_if.Run = 1;
    @(negedge Clk);
    a_if.Run = 0;
    lat = 0;
    d2 = 0;
    while (a_if.Done !== 1'b1 && lat < 200) begin
      @(negedge Clk);
      lat++;
      if (lat == 2) d2 = a_if.Drive;
      if (lat == 4) a_if.Func = late_func;
    end
    a_if.Func = 3'd1;
  endtask
  task automatic release_a();
    a_if.DISP_RSLT = 1;
    @(negedge Clk);
    a_if.DISP_RSLT = 0;
    check("Done after DISP_RSLT", 32'(a_if.Done), 32'd0);
  endtask
  initial begin
    int lat;
    logic [7:0] d2;
    a_if.Run = 0;
    a_if.Func = 3'd1;
    a_if.DISP_RSLT = 0;
    b_if.Run = 0;
    b_if.Func = 3'd7;
    b_if.DISP_RSLT = 0;
    repeat (2) @(negedge Clk);
    check("reset Done", 32'(a_if.Done), 32'd0);
    check("reset Drive", 32'(a_if.Drive), 32'd0);
    check("reset FailMask", 32'(a_if.FailMask), 32'd0);
    check("reset RSLT", 32'(a_if.RSLT), 32'd0);
    Reset = 0;
    chk_en = 1;
    @(negedge Clk);
    chip_mode = 0;
    run_a(3'd3, lat, d2);
    check("good NAND latency", 32'(lat), 32'd22);
    check("first Drive", 32'(d2), 32'hCC);
    check("good NAND RSLT", 32'(a_if.RSLT), 32'd1);
    check("good NAND FailMask", 32'(a_if.FailMask), 32'h0);
`ifdef CHIP_CHECK_CAPTURE_EN
    check("good NAND FirstFailValid", 32'(a_if.FirstFailValid), 32'd0);
`endif
    release_a();
    chip_mode = 1;
    run_a(3'd1, lat, d2);
    check("stuck latency", 32'(lat), 32'd22);
    check("stuck RSLT", 32'(a_if.RSLT), 32'd0);
    check("stuck FailMask", 32'(a_if.FailMask), 32'b0100);
`ifdef CHIP_CHECK_CAPTURE_EN
    check("stuck FirstFailVec", 32'(a_if.FirstFailVec), 32'b11);
`endif
    release_a();
    chip_mode = 2;
    run_a(3'd1, lat, d2);
    check("NOR RSLT", 32'(a_if.RSLT), 32'd0);
    check("NOR FailMask", 32'(a_if.FailMask), 32'b1111);
`ifdef CHIP_CHECK_CAPTURE_EN
    check("NOR FirstFailVec", 32'(a_if.FirstFailVec), 32'b01);
`endif
    repeat (3) begin
      a_if.Run = 1;
      @(negedge Clk);
      a_if.Run = 0;
      @(negedge Clk);
      check("Run in DONE Done", 32'(a_if.Done), 32'd1);
      check("Run in DONE FailMask", 32'(a_if.FailMask), 32'b1111);
    end
    a_if.DISP_RSLT = 1;
    a_if.Run = 1;
    @(negedge Clk);
    a_if.DISP_RSLT = 0;
    a_if.Run = 0;
    check("DISP with Run Done", 32'(a_if.Done), 32'd0);
    a_if.Run = 1;
    @(negedge Clk);
    a_if.Run = 0;
    repeat (10) @(negedge Clk);
    check("mid-test Drive", 32'(a_if.Drive), 32'h99);
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    check("abort Done", 32'(a_if.Done), 32'd0);
    check("abort Drive", 32'(a_if.Drive), 32'd0);
    check("abort FailMask", 32'(a_if.FailMask), 32'd0);
    chip_mode = 0;
    run_a(3'd1, lat, d2);
    check("after abort latency", 32'(lat), 32'd22);
    check("after abort RSLT", 32'(a_if.RSLT), 32'd1);
    release_a();
    b_if.Run = 1;
    @(negedge Clk);
    b_if.Run = 0;
    lat = 0;
    while (b_if.Done !== 1'b1 && lat < 200) begin
      @(negedge Clk);
      lat++;
      if (lat == 2) check("NOT first Drive", 32'(b_if.Drive), 32'b101010);
    end
    check("NOT latency", 32'(lat), 32'd12);
    check("NOT RSLT", 32'(b_if.RSLT), 32'd1);
    check("NOT FailMask", 32'(b_if.FailMask), 32'd0);
    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
